npc_fetch_ctrl: RTL and testbench



---
 rtl/npc_fetch_ctrl_pkg.sv | 24 ++
 rtl/npc_fetch_ctrl.sv | 151 +++++++++++++++
 tb/tb_npc_fetch_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/npc_fetch_ctrl_pkg.sv
// Shared definitions for the next-PC / instruction fetch controller.
//   fetch_state_e : fetch FSM states (ISSUE, WAIT, HOLD)
//   PC_STEP       : sequential PC increment in bytes
//   PC_RESET      : value the external PC register takes on reset
//   align_word()  : clears the low address bits of a word address
package npc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_STEP         = 32'd4;
  localparam int          ALIGN_MASK_BITS = 2;
  localparam logic [31:0] PC_RESET        = 32'h0000_3000;

  function automatic logic [31:0] align_word(input logic [31:0] addr, input int bits);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << bits;
    return addr & mask;
  endfunction

endpackage

// File: rtl/npc_fetch_ctrl.sv
// Next-PC and instruction fetch controller.
// Issues one instruction-memory read per PC value, captures the returned word,
// presents it to decode with a valid/ready handshake and steers the external
// PC register (pc_en/pc_next). Branch/jump redirects from decode win over the
// sequential increment and squash any stale in-flight fetch.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   pc_cur              current PC register value
//   pc_en, pc_next      PC register load enable / load value (combinational)
//   imem_req, imem_addr instruction memory read request pulse / address
//   imem_rvalid/rdata   instruction memory response
//   instr_valid/instr/instr_pc  captured instruction to decode (registered)
//   instr_ready         decode accepts the instruction
//   redirect_valid/target  taken branch/jump pulse and its target
//
// state | meaning
// ISSUE | no fetch in flight, no instruction held; request pc_cur
// WAIT  | one request outstanding; kill_q marks its response as stale
// HOLD  | instruction held for decode, waiting for instr_ready
module npc_fetch_ctrl
  import npc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_STEP_P         = PC_STEP,
  parameter int          ALIGN_MASK_BITS_P = ALIGN_MASK_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  output logic        pc_en,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target
);

  fetch_state_e state_q, state_d;
  logic         kill_q, kill_d;
  logic         instr_valid_q, instr_valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;

  always_comb begin
    state_d       = state_q;
    kill_d        = kill_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    pc_en         = 1'b0;
    pc_next       = '0;
    imem_req      = 1'b0;
    imem_addr     = '0;

    if (!reset) begin
      unique case (state_q)
        ISSUE: begin
          if (!redirect_valid) begin
            imem_req  = 1'b1;
            imem_addr = align_word(pc_cur, ALIGN_MASK_BITS_P);
            state_d   = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid && !redirect_valid) begin
            if (kill_q) begin
              // response to a fetch that a redirect already made stale
              kill_d  = 1'b0;
              state_d = ISSUE;
            end else begin
              instr_d       = imem_rdata;
              instr_pc_d    = pc_cur;
              instr_valid_d = 1'b1;
              pc_en         = 1'b1;
              pc_next       = align_word(pc_cur + PC_STEP_P, ALIGN_MASK_BITS_P);
              state_d       = HOLD;
            end
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid_d = 1'b0;
            state_d       = ISSUE;
          end
        end
        default: state_d = ISSUE;
      endcase

      // Redirect overrides the sequential path in every state. A request
      // still in flight without its response this cycle must be remembered
      // so its data is discarded when it finally arrives.
      if (redirect_valid) begin
        pc_en         = 1'b1;
        pc_next       = align_word(redirect_target, ALIGN_MASK_BITS_P);
        instr_valid_d = 1'b0;
        if (state_q == WAIT && !imem_rvalid) begin
          kill_d  = 1'b1;
          state_d = WAIT;
        end else begin
          kill_d  = 1'b0;
          state_d = ISSUE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ISSUE;
      kill_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      kill_q        <= kill_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

`ifndef SYNTHESIS
  // A response is only legal while a request is outstanding. The one
  // exception is the window between reset and the first new request, where
  // memory may still return the answer to a request abandoned by reset.
  logic post_reset_q;
  always_ff @(posedge clk) begin
    if (reset)
      post_reset_q <= 1'b1;
    else if (imem_req)
      post_reset_q <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset && imem_rvalid && !post_reset_q)
      assert (state_q == WAIT);
  end
`endif

endmodule

// File: tb/tb_npc_fetch_ctrl.sv
// Directed bench for npc_fetch_ctrl with an occupancy-level reference model
// (fetch outstanding / response stale / instruction held) and a per-cycle
// compare process, plus literal spot checks at key points of each scenario.
module tb_npc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_cur;
  logic        pc_en;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  npc_fetch_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .pc_cur          (pc_cur),
    .pc_en           (pc_en),
    .pc_next         (pc_next),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target)
  );

  // external PC register
  logic [31:0] pc_reg;
  always @(posedge clk) begin
    if (reset) pc_reg <= 32'h0000_3000;
    else if (pc_en) pc_reg <= pc_next;
  end
  assign pc_cur = pc_reg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] al(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // ---------------- reference model ----------------
  logic        m_out   = 1'b0;   // a fetch is in flight
  logic        m_stale = 1'b0;   // that fetch was made stale by a redirect
  logic        m_held  = 1'b0;   // an instruction is offered to decode
  logic [31:0] m_pc    = 32'h0000_3000;
  logic [31:0] m_instr = '0;
  logic [31:0] m_ipc   = '0;

  logic        e_req;
  logic        e_pc_en;
  logic [31:0] e_pc_next;

  always_comb begin
    e_req     = !reset && !m_out && !m_held && !redirect_valid;
    e_pc_en   = 1'b0;
    e_pc_next = '0;
    if (!reset) begin
      if (redirect_valid) begin
        e_pc_en   = 1'b1;
        e_pc_next = al(redirect_target);
      end else if (m_out && imem_rvalid && !m_stale) begin
        e_pc_en   = 1'b1;
        e_pc_next = m_pc + 32'd4;
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      m_out = 1'b0; m_stale = 1'b0; m_held = 1'b0;
      m_pc = 32'h0000_3000; m_instr = '0; m_ipc = '0;
    end else if (redirect_valid) begin
      m_pc   = al(redirect_target);
      m_held = 1'b0;
      if (m_out && !imem_rvalid) m_stale = 1'b1;
      else begin m_out = 1'b0; m_stale = 1'b0; end
    end else if (e_req) begin
      m_out = 1'b1;
    end else if (m_out && imem_rvalid) begin
      if (!m_stale) begin
        m_held = 1'b1; m_instr = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 32'd4;
      end
      m_out = 1'b0; m_stale = 1'b0;
    end else if (m_held && instr_ready) begin
      m_held = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
    if (e_req) chk("imem_addr", imem_addr, al(m_pc));
    if (reset) chk("imem_addr_rst", imem_addr, 32'd0);
    chk("pc_en", {31'd0, pc_en}, {31'd0, e_pc_en});
    if (e_pc_en || reset) chk("pc_next", pc_next, e_pc_next);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_held});
    if (m_held) begin
      chk("instr", instr, m_instr);
      chk("instr_pc", instr_pc, m_ipc);
    end
    if (!reset) chk("pc_cur", pc_cur, m_pc);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: run did not end, limit 100000 ns");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    reset = 1'b1;
    tick(); tick();
    #1;
    chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);

    // basic fetch, 1-cycle memory, decode ready
    tick(); reset = 1'b0; instr_ready = 1'b1; #1;
    chk("t1_req", {31'd0, imem_req}, 32'd1);
    chk("t1_addr", imem_addr, 32'h0000_3000);
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'h2408_0001; #1;
    chk("t1_pc_en", {31'd0, pc_en}, 32'd1);
    chk("t1_pc_next", pc_next, 32'h0000_3004);
    tick(); imem_rvalid = 1'b0; #1;
    chk("t1_instr", instr, 32'h2408_0001);
    chk("t1_instr_pc", instr_pc, 32'h0000_3000);
    tick(); #1;
    chk("t1_next_addr", imem_addr, 32'h0000_3004);

    // decode stalls for 5 cycles
    instr_ready = 1'b0;
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222;
    tick(); imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_valid", {31'd0, instr_valid}, 32'd1);
      chk("t2_instr", instr, 32'h1111_2222);
      chk("t2_instr_pc", instr_pc, 32'h0000_3004);
      chk("t2_no_req", {31'd0, imem_req}, 32'd0);
      chk("t2_no_pc_en", {31'd0, pc_en}, 32'd0);
      tick();
    end
    instr_ready = 1'b1;
    tick(); #1;
    chk("t2_next_addr", imem_addr, 32'h0000_3008);

    // redirect while waiting, stale response 2 cycles later
    tick(); redirect_valid = 1'b1; redirect_target = 32'h0000_3040; #1;
    chk("t3_pc_en", {31'd0, pc_en}, 32'd1);
    chk("t3_pc_next", pc_next, 32'h0000_3040);
    tick(); redirect_valid = 1'b0; #1;
    chk("t3_idle_req", {31'd0, imem_req}, 32'd0);
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    chk("t3_drop_pc_en", {31'd0, pc_en}, 32'd0);
    tick(); imem_rvalid = 1'b0; #1;
    chk("t3_valid", {31'd0, instr_valid}, 32'd0);
    chk("t3_addr", imem_addr, 32'h0000_3040);

    // redirect and response in the same cycle, unaligned target
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
    redirect_valid = 1'b1; redirect_target = 32'h0000_3103; #1;
    chk("t4_pc_next", pc_next, 32'h0000_3100);
    tick(); imem_rvalid = 1'b0; redirect_valid = 1'b0; #1;
    chk("t4_valid", {31'd0, instr_valid}, 32'd0);
    chk("t4_addr", imem_addr, 32'h0000_3100);

    // redirect in ISSUE to the top word, then wrap of the increment
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC; #1;
    chk("t5_no_req", {31'd0, imem_req}, 32'd0);
    chk("t5_pc_next", pc_next, 32'hFFFF_FFFC);
    tick(); redirect_valid = 1'b0; #1;
    chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_F00D; #1;
    chk("t5_wrap", pc_next, 32'h0000_0000);
    tick(); imem_rvalid = 1'b0; #1;
    chk("t5_instr_pc", instr_pc, 32'hFFFF_FFFC);
    tick(); #1;
    chk("t5_addr0", imem_addr, 32'h0000_0000);

    // redirect while holding, decode accepting the same cycle
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'h2222_3333;
    tick(); imem_rvalid = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h0000_3200; #1;
    chk("t6_pc_next", pc_next, 32'h0000_3200);
    tick(); redirect_valid = 1'b0; #1;
    chk("t6_squash", {31'd0, instr_valid}, 32'd0);
    chk("t6_addr", imem_addr, 32'h0000_3200);

    // reset while waiting, stale response right after release
    tick(); reset = 1'b1; #1;
    chk("t7_rst_req", {31'd0, imem_req}, 32'd0);
    tick(); tick();
    reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0; #1;
    chk("t7_req", {31'd0, imem_req}, 32'd1);
    chk("t7_addr", imem_addr, 32'h0000_3000);
    chk("t7_pc_en", {31'd0, pc_en}, 32'd0);
    tick(); imem_rvalid = 1'b0; #1;
    chk("t7_valid", {31'd0, instr_valid}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678; #1;
    chk("t7_pc_next", pc_next, 32'h0000_3004);
    tick(); imem_rvalid = 1'b0; #1;
    chk("t7_instr", instr, 32'h1234_5678);
    chk("t7_instr_pc", instr_pc, 32'h0000_3000);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
